// File: rtl/ram_rd_streamer_if.sv
// ram_rd_streamer_if: control, RAM read port and output beat stream of the streamer
interface ram_rd_streamer_if #(
    parameter int DataWidth  = 8,
    parameter int NumEntries = 512
);
    localparam int AW = $clog2(NumEntries);
    logic                 start_i;
    logic [AW-1:0]        base_addr_i;
    logic [AW:0]          len_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 rd_valid_o;
    logic [AW-1:0]        rd_addr_o;
    logic [DataWidth-1:0] rd_data_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [DataWidth-1:0] data_o;
    logic                 last_o;
    modport master (
        input  start_i, base_addr_i, len_i, rd_data_i, ready_i,
        output busy_o, done_o, rd_valid_o, rd_addr_o, valid_o, data_o, last_o
    );
    modport slave (
        output start_i, base_addr_i, len_i, rd_data_i, ready_i,
        input  busy_o, done_o, rd_valid_o, rd_addr_o, valid_o, data_o, last_o
    );
endinterface

// File: rtl/ram_rd_streamer.sv
// ram_rd_streamer: streams len RAM words from base_addr out as valid/ready beats; RAM_RD_STREAMER_WRAP_EN wraps the address at the top
module ram_rd_streamer #(
    parameter int DataWidth  = 8,
    parameter int NumEntries = 512
) (
    input logic               clk_i,
    input logic               reset_i,
    ram_rd_streamer_if.master bus
);
    localparam int AW = $clog2(NumEntries);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
    state_e               state_q, state_d;
    logic [AW-1:0]        addr_q, addr_d, next_addr;
    logic [AW:0]          rem_q, rem_d;
    logic                 done_q, done_d;
    logic                 inflight_q, inflight_last_q;
    logic [DataWidth-1:0] buf_data_q [2];
    logic                 buf_last_q [2];
    logic                 rd_ptr_q, wr_ptr_q;
    logic [1:0]           cnt_q;
    logic                 issue, final_rd, out_valid, out_last, push, pop;
    logic [DataWidth-1:0] out_data;
    wire addr_end = addr_q == AW'(NumEntries - 1);
`ifdef RAM_RD_STREAMER_WRAP_EN
    assign next_addr = addr_end ? '0 : addr_q + AW'(1);
    assign final_rd  = rem_q == (AW+1)'(1);
`else
    assign next_addr = addr_q + AW'(1);
    assign final_rd  = rem_q == (AW+1)'(1) || addr_end;
`endif
    // The in-flight read reserves a buffer slot so returning data always has room.
    assign issue     = state_q == RUN && (cnt_q + 2'(inflight_q)) < 2'd2;
    assign out_valid = cnt_q != 2'd0 || inflight_q;
    assign out_data  = cnt_q != 2'd0 ? buf_data_q[rd_ptr_q] : inflight_q ? bus.rd_data_i : '0;
    assign out_last  = cnt_q != 2'd0 ? buf_last_q[rd_ptr_q] : inflight_q && inflight_last_q;
    assign push      = inflight_q && (cnt_q != 2'd0 || !bus.ready_i);
    assign pop       = cnt_q != 2'd0 && bus.ready_i;
    assign bus.busy_o     = state_q != IDLE;
    assign bus.done_o     = done_q;
    assign bus.rd_valid_o = issue;
    assign bus.rd_addr_o  = addr_q;
    assign bus.valid_o    = out_valid;
    assign bus.data_o     = out_data;
    assign bus.last_o     = out_last;
    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end
    // Next-state, address and remaining-count logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.start_i) begin
                if (bus.len_i != '0) begin
                    state_d = RUN;
                    addr_d  = bus.base_addr_i;
                    rem_d   = bus.len_i;
                end else begin
                    done_d = 1'b1;
                end
            end
            RUN: if (issue) begin
                addr_d  = next_addr;
                rem_d   = rem_q - (AW+1)'(1);
                state_d = final_rd ? DRAIN : RUN;
            end
            DRAIN: if (out_valid && bus.ready_i && out_last) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    // Datapath: read tracking and the 2-entry fall-through output buffer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q          <= '0;
            rem_q           <= '0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            buf_data_q[0]   <= '0;
            buf_data_q[1]   <= '0;
            buf_last_q[0]   <= 1'b0;
            buf_last_q[1]   <= 1'b0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            cnt_q           <= 2'd0;
        end else begin
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            done_q          <= done_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && final_rd;
            if (push) begin
                buf_data_q[wr_ptr_q] <= bus.rd_data_i;
                buf_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_ram_rd_streamer.sv
// tb_ram_rd_streamer: randomized and directed checks of ram_rd_streamer against a queue-based reference model
module tb_ram_rd_streamer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic       start = 1'b0;
    logic [8:0] base = '0;
    logic [9:0] len = '0;
    logic       ready = 1'b0;

    ram_rd_streamer_if #(.DataWidth(8), .NumEntries(512)) bb ();
    ram_rd_streamer_if #(.DataWidth(8), .NumEntries(16))  bs ();

    ram_rd_streamer #(.DataWidth(8), .NumEntries(512)) dut_b (.clk_i(clk), .reset_i(rst), .bus(bb.master));
    ram_rd_streamer #(.DataWidth(8), .NumEntries(16))  dut_s (.clk_i(clk), .reset_i(rst), .bus(bs.master));

    assign bb.start_i     = start & ~sel;
    assign bb.base_addr_i = base;
    assign bb.len_i       = len;
    assign bb.ready_i     = ready;
    assign bs.start_i     = start & sel;
    assign bs.base_addr_i = base[3:0];
    assign bs.len_i       = len[4:0];
    assign bs.ready_i     = ready;

    logic       o_valid, o_last, o_done, o_busy, o_rdv;
    logic [7:0] o_data;
    logic [8:0] o_addr;
    assign o_valid = sel ? bs.valid_o    : bb.valid_o;
    assign o_last  = sel ? bs.last_o     : bb.last_o;
    assign o_done  = sel ? bs.done_o     : bb.done_o;
    assign o_busy  = sel ? bs.busy_o     : bb.busy_o;
    assign o_rdv   = sel ? bs.rd_valid_o : bb.rd_valid_o;
    assign o_data  = sel ? bs.data_o     : bb.data_o;
    assign o_addr  = sel ? {5'b0, bs.rd_addr_o} : bb.rd_addr_o;

    logic [7:0] mem_b [512];
    logic [7:0] mem_s [16];
    always @(posedge clk) begin
        if (bb.rd_valid_o) bb.rd_data_i <= mem_b[bb.rd_addr_o];
        if (bs.rd_valid_o) bs.rd_data_i <= mem_s[bs.rd_addr_o];
    end

    int checks = 0;
    int passes = 0;
    logic [7:0] exp_d [$];
    logic       exp_l [$];

    task automatic build_exp(input bit s, input int b, input int l);
        int n;
        int a;
        n = s ? 16 : 512;
        exp_d.delete();
        exp_l.delete();
        for (int k = 0; k < l; k++) begin
            a = b + k;
`ifdef RAM_RD_STREAMER_WRAP_EN
            a = a % n;
`else
            if (a >= n) break;
`endif
            exp_d.push_back(s ? mem_s[a] : mem_b[a]);
        end
        for (int i = 0; i < exp_d.size(); i++) exp_l.push_back(i == exp_d.size() - 1);
    endtask

    task automatic run_xfer(input bit s, input int b, input int l, input int mode, input int restart_cyc,
                            output int first_cyc, output int done_cyc);
        int cyc, got, reads, budget;
        bit prev_stall;
        logic [7:0] pd;
        logic pl;
        build_exp(s, b, l);
        budget = 4 * l + 40;
        @(negedge clk);
        sel = s; start = 1'b1; base = 9'(b); len = 10'(l); ready = 1'b0;
        cyc = 0; got = 0; reads = 0; first_cyc = -1; done_cyc = -1; prev_stall = 0; pd = '0; pl = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = (cyc == restart_cyc);
            if (start) begin len = 10'(l + 5); base = 9'(b + 1); end
            if (o_rdv) reads++;
            if (cyc == 1) begin
                checks++;
                if (o_rdv !== 1'b1 || o_addr !== 9'(b))
                    $display("FAIL first_read: rd_valid=%0b addr=%0d, want 1 addr=%0d", o_rdv, o_addr, b);
                else passes++;
            end
            if (prev_stall) begin
                checks++;
                if (o_valid !== 1'b1 || o_data !== pd || o_last !== pl)
                    $display("FAIL stall_hold: valid=%0b data=%0h last=%0b, want 1 data=%0h last=%0b", o_valid, o_data, o_last, pd, pl);
                else passes++;
            end
            if (o_done) begin done_cyc = cyc; break; end
            ready = mode == 0 ? 1'b1 : mode == 1 ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
            if (o_valid && first_cyc < 0) first_cyc = cyc;
            if (o_valid && ready) begin
                checks++;
                if (got >= exp_d.size() || o_data !== exp_d[got] || o_last !== exp_l[got])
                    $display("FAIL beat[%0d]: data=%0h last=%0b, want data=%0h last=%0b (expected beats %0d)",
                             got, o_data, o_last, got < exp_d.size() ? exp_d[got] : 8'h0,
                             got < exp_l.size() ? exp_l[got] : 1'b0, exp_d.size());
                else passes++;
                got++;
            end
            prev_stall = o_valid && !ready;
            pd = o_data;
            pl = o_last;
        end
        start = 1'b0;
        checks++;
        if (done_cyc < 0 || got != exp_d.size() || reads != exp_d.size() || o_busy !== 1'b0)
            $display("FAIL completion b=%0d l=%0d: done_cyc=%0d beats=%0d reads=%0d busy=%0b, want beats=reads=%0d busy=0",
                     b, l, done_cyc, got, reads, o_busy, exp_d.size());
        else passes++;
        @(negedge clk);
        ready = 1'b0;
        checks++;
        if (o_done !== 1'b0 || o_valid !== 1'b0 || o_rdv !== 1'b0)
            $display("FAIL after_done: done=%0b valid=%0b rd_valid=%0b, want 0 0 0", o_done, o_valid, o_rdv);
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bb.busy_o, bb.done_o, bb.rd_valid_o, bb.valid_o, bb.last_o, bb.data_o, bb.rd_addr_o} !== '0 ||
            {bs.busy_o, bs.done_o, bs.rd_valid_o, bs.valid_o, bs.last_o, bs.data_o, bs.rd_addr_o} !== '0)
            $display("FAIL reset_state: busy=%0b done=%0b rdv=%0b valid=%0b last=%0b data=%0h addr=%0d, want all 0",
                     bb.busy_o, bb.done_o, bb.rd_valid_o, bb.valid_o, bb.last_o, bb.data_o, bb.rd_addr_o);
        else passes++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int f, d;
        run_xfer(0, 4, 3, 0, 0, f, d);
        checks++;
        if (f != 2 || d != 5) $display("FAIL basic_timing: first_valid=%0d done=%0d, want 2 and 5", f, d);
        else passes++;
    endtask

    task automatic test_backpressure();
        int f, d;
        run_xfer(0, 0, 8, 1, 0, f, d);
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        sel = 1'b0; start = 1'b1; base = 9'd33; len = '0; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_rdv !== 1'b0 || o_valid !== 1'b0)
            $display("FAIL zero_len_c1: done=%0b busy=%0b rdv=%0b valid=%0b, want 1 0 0 0", o_done, o_busy, o_rdv, o_valid);
        else passes++;
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_rdv !== 1'b0 || o_valid !== 1'b0)
            $display("FAIL zero_len_c2: done=%0b busy=%0b rdv=%0b valid=%0b, want 0 0 0 0", o_done, o_busy, o_rdv, o_valid);
        else passes++;
        ready = 1'b0;
    endtask

    task automatic test_boundary();
        int f, d;
        run_xfer(1, 14, 4, 2, 0, f, d);
        run_xfer(0, 508, 10, 2, 0, f, d);
    endtask

    task automatic test_reset_mid();
        int f, d, cyc, got;
        bit bad;
        @(negedge clk);
        sel = 1'b0; start = 1'b1; base = '0; len = 10'd10; ready = 1'b1;
        cyc = 0; got = 0;
        while (got < 2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (o_valid && ready) got++;
        end
        checks++;
        if (got != 2) $display("FAIL reset_mid_beats: beats=%0d, want 2", got);
        else passes++;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bb.busy_o, bb.done_o, bb.rd_valid_o, bb.valid_o, bb.last_o, bb.data_o, bb.rd_addr_o} !== '0)
            $display("FAIL reset_mid_outputs: busy=%0b done=%0b rdv=%0b valid=%0b last=%0b data=%0h addr=%0d, want all 0",
                     bb.busy_o, bb.done_o, bb.rd_valid_o, bb.valid_o, bb.last_o, bb.data_o, bb.rd_addr_o);
        else passes++;
        rst = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_done !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) $display("FAIL reset_mid_quiet: saw done/valid/busy after reset, want none");
        else passes++;
        ready = 1'b0;
        run_xfer(0, 0, 2, 0, 0, f, d);
    endtask

    task automatic test_restart();
        int f, d;
        run_xfer(0, 20, 6, 0, 2, f, d);
        run_xfer(1, 3, 9, 2, 4, f, d);
    endtask

    task automatic test_random();
        int f, d;
        bit s;
        for (int i = 0; i < 512; i++) mem_b[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) mem_s[i] = 8'($urandom);
        for (int t = 0; t < 14; t++) begin
            s = 1'($urandom_range(0, 1));
            if (s) run_xfer(1, $urandom_range(0, 15), $urandom_range(1, 16), 2, 0, f, d);
            else   run_xfer(0, $urandom_range(0, 511), $urandom_range(1, 24), 2, 0, f, d);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem_b[i] = 8'(i);
        for (int i = 0; i < 16; i++) mem_s[i] = 8'(i);
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_boundary();
        test_reset_mid();
        test_restart();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/ram_rd_streamer.md
RAM_RD_STREAMER -- requirements
Module: ram_rd_streamer

Interface
REQ-001 Parameter: DataWidth, default 8, width of a RAM word and of each output beat.
REQ-002 Parameter: NumEntries, default 512, RAM depth; AW = $clog2(NumEntries).
REQ-003 Port: clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-004 Port: reset_i, input, 1, reset; synchronous and active-high.
REQ-005 Port: start_i, input, 1, one-cycle transfer request, sampled only in IDLE.
REQ-006 Port: base_addr_i, input, AW, first RAM address, captured with start_i.
REQ-007 Port: len_i, input, AW+1, number of words to read (0..NumEntries), captured with start_i.
REQ-008 Port: busy_o, output, 1, high while not in IDLE.
REQ-009 Port: done_o, output, 1, one-cycle pulse at transfer completion.
REQ-010 Port: rd_valid_o, output, 1, RAM read enable.
REQ-011 Port: rd_addr_o, output, AW, RAM read address.
REQ-012 Port: rd_data_i, input, DataWidth, RAM read data, valid exactly one cycle after rd_valid_o.
REQ-013 Port: valid_o, output, 1, output beat valid.
REQ-014 Port: ready_i, input, 1, downstream ready; a beat transfers when valid_o and ready_i are both high.
REQ-015 Port: data_o, output, DataWidth, output beat data.
REQ-016 Port: last_o, output, 1, marks the final beat, qualified by valid_o.

Function
REQ-017 States SHALL be IDLE, RUN and DRAIN.
- IDLE -> RUN on start_i with len_i != 0.
- RUN -> DRAIN after the final read is issued.
- DRAIN -> IDLE on the handshake of the last beat.
REQ-018 start_i with len_i == 0 SHALL stay in IDLE, issue no reads, and pulse done_o on the next cycle.
REQ-019 start_i SHALL be ignored while busy_o is high.
REQ-020 The first rd_valid_o SHALL assert in the cycle after start_i is accepted, with rd_addr_o = base_addr_i.
REQ-021 Each subsequent read SHALL use the previous address + 1.
REQ-022 Read order: the block SHALL issue exactly len reads and emit exactly len beats, in address order, with no loss or duplication under any ready_i pattern.
REQ-023 Buffering: a 2-entry output buffer SHALL absorb the 1-cycle RAM latency.
- A read SHALL issue only if (buffered + in-flight) < 2.
REQ-024 Throughput: with ready_i held high, beats SHALL stream at 1 per cycle, first valid_o two cycles after start_i.
REQ-025 Backpressure: while valid_o is high and ready_i is low, data_o and last_o SHALL hold stable.
REQ-026 Completion: last_o SHALL be high only on beat number len.
- done_o SHALL pulse the cycle after that beat's handshake, with busy_o low in that same cycle.
REQ-027 Address boundary: behaviour when the next address would exceed NumEntries-1 is set by REQ-031/REQ-032.
REQ-028 Idle outputs: rd_valid_o and valid_o SHALL be low whenever the block is not in RUN or DRAIN.

Reset
REQ-029 reset_i SHALL force the following on the next edge, from any state:
- state IDLE;
- busy_o, done_o, rd_valid_o, valid_o and last_o = 0;
- rd_addr_o and data_o = 0;
- buffer emptied.
REQ-030 Reset mid-transfer SHALL abandon the transfer, and SHALL NOT pulse done_o.

Configuration
REQ-031 With RAM_RD_STREAMER_WRAP_EN defined, the read address SHALL wrap from NumEntries-1 to 0, and all len words are read.
REQ-032 Without RAM_RD_STREAMER_WRAP_EN, the transfer SHALL end after reading address NumEntries-1.
- That beat SHALL carry last_o = 1.
- Fewer than len beats are emitted; done_o behaves per REQ-026.

Verification
REQ-033 RAM preloaded mem[i] = i, start base=4 len=3, ready_i=1 -> beats 4,5,6 on cycles 2,3,4; last_o on 6; done_o on cycle 5.
REQ-034 Same preload, start base=0 len=8, ready_i toggling 1,0 each cycle -> 8 beats 0..7 in order, data stable during stalls, exactly 8 reads issued.
REQ-035 start len=0 -> no rd_valid_o, no valid_o, done_o pulses on cycle 1.
REQ-036 NumEntries=16, start base=14 len=4:
- WRAP_EN defined -> beats 14,15,0,1;
- WRAP_EN undefined -> beats 14,15 with last_o on 15.
REQ-037 Assert reset_i after the 2nd beat of a len=10 transfer -> next cycle all outputs 0, no done_o; a new start base=0 len=2 then completes normally.
REQ-038 start_i pulsed again during RUN -> ignored; beat count equals the original len.
